complex_div: RTL and testbench

COMPLEX_DIV -- requirements
Module: complex_div

---
 rtl/complex_div.sv | 195 +++++++++++++++++++
 tb/tb_complex_div.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/complex_div.sv
// complex_div -- sequential signed complex divider.
//
// Computes (A1 + jA2) / (B1 + jB2) = N1/D + j(N2/D) with
//   N1 = A1*B1 + A2*B2,  N2 = A2*B1 - A1*B2,  D = B1*B1 + B2*B2
// using two restoring shift-subtract dividers running in parallel.
//
// FSM: IDLE -> SETUP (two cycles) -> DIV (ITER cycles) -> FIX -> DONE -> IDLE.
//      If D == 0, SETUP goes straight to DONE.
// Latency: start sampled at edge k gives done in the cycle after edge
//   k+ITER+3 when D != 0, or after edge k+2 when D == 0.
//
// Handshake: start is sampled only while busy is low (IDLE). The request
// is accepted at that edge and the operands are captured. busy then stays
// high until the FSM returns to IDLE. done pulses for one cycle, in the
// same cycle that Out1/Out2/DivByZero first show the new result.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   start      division request (ignored while busy)
//   A1, A2     dividend real/imaginary, two's complement
//   B1, B2     divisor real/imaginary, two's complement
//   busy       high in every state except IDLE
//   done       one-cycle completion pulse
//   Out1, Out2 quotient real/imaginary, low NUMBER_SIZE bits (wrap-around)
//   DivByZero  last completed operation had a zero divisor
//
// Configuration macro COMPLEX_DIV_ROUND_EN: when defined, quotients round
// half away from zero. When not defined, quotients truncate toward zero.
module complex_div #(
  parameter int NUMBER_SIZE = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [NUMBER_SIZE-1:0] A1,
  input  logic [NUMBER_SIZE-1:0] A2,
  input  logic [NUMBER_SIZE-1:0] B1,
  input  logic [NUMBER_SIZE-1:0] B2,
  output logic                   busy,
  output logic                   done,
  output logic [NUMBER_SIZE-1:0] Out1,
  output logic [NUMBER_SIZE-1:0] Out2,
  output logic                   DivByZero
);

  localparam int N    = NUMBER_SIZE;
  localparam int W    = 2*N + 1;
  localparam int ITER = W;
  localparam int CW   = $clog2(ITER + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_DIV   = 3'd2;
  localparam logic [2:0] S_FIX   = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]    state_q, state_d;
  logic          setup_ph_q, setup_ph_d;
  logic [N-1:0]  a1_q, a1_d, a2_q, a2_d, b1_q, b1_d, b2_q, b2_d;
  logic [W-1:0]  n1_q, n1_d, n2_q, n2_d, d_q, d_d;
  logic          neg1_q, neg1_d, neg2_q, neg2_d;
  logic [W-1:0]  r1_q, r1_d, r2_q, r2_d, q1_q, q1_d, q2_q, q2_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  out1_q, out1_d, out2_q, out2_d;
  logic          dbz_q, dbz_d;

  // Sign-extend operands to W bits so the products and sums cannot overflow.
  logic signed [W-1:0] a1_x, a2_x, b1_x, b2_x;
  logic signed [W-1:0] n1_c, n2_c, d_c;
  assign a1_x = {{(W-N){a1_q[N-1]}}, a1_q};
  assign a2_x = {{(W-N){a2_q[N-1]}}, a2_q};
  assign b1_x = {{(W-N){b1_q[N-1]}}, b1_q};
  assign b2_x = {{(W-N){b2_q[N-1]}}, b2_q};
  assign n1_c = a1_x*b1_x + a2_x*b2_x;
  assign n2_c = a2_x*b1_x - a1_x*b2_x;
  assign d_c  = b1_x*b1_x + b2_x*b2_x;

  // One restoring step per divider. The remainder is always below D, so
  // the shifted remainder fits W+1 bits. The top bit of diff is the borrow.
  logic [W:0]   r1_sh, r2_sh, diff1, diff2;
  logic         ge1, ge2;
  assign r1_sh = {r1_q, q1_q[W-1]};
  assign r2_sh = {r2_q, q2_q[W-1]};
  assign diff1 = r1_sh - {1'b0, d_q};
  assign diff2 = r2_sh - {1'b0, d_q};
  assign ge1   = ~diff1[W];
  assign ge2   = ~diff2[W];

  // Only the low N quotient bits are kept. The upper bits wrap away.
  logic [N-1:0] mag1, mag2;
`ifdef COMPLEX_DIV_ROUND_EN
  logic rnd1, rnd2;
  assign rnd1 = ({r1_q, 1'b0} >= {1'b0, d_q});
  assign rnd2 = ({r2_q, 1'b0} >= {1'b0, d_q});
  assign mag1 = q1_q[N-1:0] + {{(N-1){1'b0}}, rnd1};
  assign mag2 = q2_q[N-1:0] + {{(N-1){1'b0}}, rnd2};
`else
  assign mag1 = q1_q[N-1:0];
  assign mag2 = q2_q[N-1:0];
`endif

  logic unused_q_hi;
  assign unused_q_hi = ^{q1_q[W-1:N], q2_q[W-1:N]};

  always_comb begin
    state_d    = state_q;
    setup_ph_d = setup_ph_q;
    a1_d = a1_q; a2_d = a2_q; b1_d = b1_q; b2_d = b2_q;
    n1_d = n1_q; n2_d = n2_q; d_d = d_q;
    neg1_d = neg1_q; neg2_d = neg2_q;
    r1_d = r1_q; r2_d = r2_q; q1_d = q1_q; q2_d = q2_q;
    cnt_d  = cnt_q;
    out1_d = out1_q; out2_d = out2_q; dbz_d = dbz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          a1_d = A1; a2_d = A2; b1_d = B1; b2_d = B2;
          setup_ph_d = 1'b0;
          state_d    = S_SETUP;
        end
      end
      S_SETUP: begin
        if (!setup_ph_q) begin
          // First cycle: register the products.
          n1_d = n1_c;
          n2_d = n2_c;
          d_d  = d_c;
          setup_ph_d = 1'b1;
        end else begin
          // Second cycle: check D for zero and load the magnitudes.
          setup_ph_d = 1'b0;
          if (d_q == '0) begin
            out1_d  = '0;
            out2_d  = '0;
            dbz_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            neg1_d  = n1_q[W-1];
            neg2_d  = n2_q[W-1];
            q1_d    = n1_q[W-1] ? (~n1_q + 1'b1) : n1_q;
            q2_d    = n2_q[W-1] ? (~n2_q + 1'b1) : n2_q;
            r1_d    = '0;
            r2_d    = '0;
            cnt_d   = CW'(ITER - 1);
            state_d = S_DIV;
          end
        end
      end
      S_DIV: begin
        r1_d = ge1 ? diff1[W-1:0] : r1_sh[W-1:0];
        r2_d = ge2 ? diff2[W-1:0] : r2_sh[W-1:0];
        q1_d = {q1_q[W-2:0], ge1};
        q2_d = {q2_q[W-2:0], ge2};
        if (cnt_q == '0) state_d = S_FIX;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_FIX: begin
        out1_d  = neg1_q ? (~mag1 + 1'b1) : mag1;
        out2_d  = neg2_q ? (~mag2 + 1'b1) : mag2;
        dbz_d   = 1'b0;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE; setup_ph_q <= 1'b0;
      a1_q <= '0; a2_q <= '0; b1_q <= '0; b2_q <= '0;
      n1_q <= '0; n2_q <= '0; d_q <= '0;
      neg1_q <= 1'b0; neg2_q <= 1'b0;
      r1_q <= '0; r2_q <= '0; q1_q <= '0; q2_q <= '0;
      cnt_q <= '0;
      out1_q <= '0; out2_q <= '0; dbz_q <= 1'b0;
    end else begin
      state_q <= state_d; setup_ph_q <= setup_ph_d;
      a1_q <= a1_d; a2_q <= a2_d; b1_q <= b1_d; b2_q <= b2_d;
      n1_q <= n1_d; n2_q <= n2_d; d_q <= d_d;
      neg1_q <= neg1_d; neg2_q <= neg2_d;
      r1_q <= r1_d; r2_q <= r2_d; q1_q <= q1_d; q2_q <= q2_d;
      cnt_q <= cnt_d;
      out1_q <= out1_d; out2_q <= out2_d; dbz_q <= dbz_d;
    end
  end

  assign busy      = (state_q != S_IDLE);
  assign done      = (state_q == S_DONE);
  assign Out1      = out1_q;
  assign Out2      = out2_q;
  assign DivByZero = dbz_q;

endmodule

// File: tb/tb_complex_div.sv
// Bench for complex_div: directed cases, a restart-while-busy case, a reset
// abort, and randomized operands checked against an integer-arithmetic model.
module tb_complex_div;

  localparam int N    = 8;
  localparam int ITER = 2*N + 1;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [N-1:0] A1, A2, B1, B2;
  logic         busy, done, DivByZero;
  logic [N-1:0] Out1, Out2;

  int n_checks = 0;
  int n_errors = 0;
  logic [2*N:0] exp_q[$];

  complex_div #(.NUMBER_SIZE(N)) dut (
    .clk(clk), .rst(rst), .start(start),
    .A1(A1), .A2(A2), .B1(B1), .B2(B2),
    .busy(busy), .done(done),
    .Out1(Out1), .Out2(Out2), .DivByZero(DivByZero)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: quotient of n/d by plain integer arithmetic.
  function automatic int ref_quot(input int n, input int d);
    int q;
    q = n / d;                      // truncates toward zero
`ifdef COMPLEX_DIV_ROUND_EN
    begin
      int an, rem;
      an  = (n < 0) ? -n : n;
      rem = an % d;
      if (2*rem >= d) q = (n < 0) ? q - 1 : q + 1;
    end
`endif
    return q;
  endfunction

  // Returns {DivByZero, Out2, Out1}.
  function automatic logic [2*N:0] model(input logic signed [N-1:0] a1, a2, b1, b2);
    int n1, n2, d;
    logic [N-1:0] o1, o2;
    n1 = int'(a1)*int'(b1) + int'(a2)*int'(b2);
    n2 = int'(a2)*int'(b1) - int'(a1)*int'(b2);
    d  = int'(b1)*int'(b1) + int'(b2)*int'(b2);
    if (d == 0) return {1'b1, {(2*N){1'b0}}};
    o1 = N'(ref_quot(n1, d));
    o2 = N'(ref_quot(n2, d));
    return {1'b0, o2, o1};
  endfunction

  task automatic scramble_inputs();
    A1 = N'($urandom_range(0, 255)); A2 = N'($urandom_range(0, 255));
    B1 = N'($urandom_range(0, 255)); B2 = N'($urandom_range(0, 255));
  endtask

  // Driver + scoreboard for one operation. Called at #1 after an edge with
  // the DUT idle. If poke is set, a second start with new operands is
  // driven while the first is in flight.
  task automatic run_op(input logic [N-1:0] a1, a2, b1, b2, input bit poke);
    int lat, exp_lat, d;
    bit extra;
    logic [2*N:0] e;
    d = int'($signed(b1))*int'($signed(b1)) + int'($signed(b2))*int'($signed(b2));
    exp_lat = (d == 0) ? 2 : ITER + 3;
    exp_q.push_back(model(a1, a2, b1, b2));
    A1 = a1; A2 = a2; B1 = b1; B2 = b2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    scramble_inputs();
    lat = 0;
    while (!done && lat < 60) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) check("busy_in_flight", busy, 1);
      if (poke && lat == 5) start = 1'b1;
      if (lat == 6) start = 1'b0;
      scramble_inputs();
    end
    start = 1'b0;
    e = exp_q.pop_front();
    if (!done) begin
      check("done_timeout", 0, 1);
    end else begin
      check("latency", lat, exp_lat);
      check("out1", Out1, e[N-1:0]);
      check("out2", Out2, e[2*N-1:N]);
      check("div_by_zero", DivByZero, e[2*N]);
    end
    @(posedge clk); #1;
    check("done_one_cycle", done, 0);
    check("idle_after_done", busy, 0);
    if (poke) begin
      extra = 1'b0;
      repeat (30) begin
        @(posedge clk); #1;
        if (done) extra = 1'b1;
      end
      check("no_second_done", extra, 0);
      check("out1_held", Out1, e[N-1:0]);
    end
  endtask

  initial begin
    bit saw_done;
    rst = 1'b1; start = 1'b0;
    A1 = '0; A2 = '0; B1 = '0; B2 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_out1", Out1, 0);
    check("rst_out2", Out2, 0);
    check("rst_dbz", DivByZero, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // directed cases
    run_op(8'd4,   8'd2, 8'd1,   8'd1, 1'b0);
    run_op(8'd7,   8'd0, 8'd2,   8'd0, 1'b0);
    run_op(8'hF9,  8'd0, 8'd2,   8'd0, 1'b0);
    run_op(8'd5,   8'd3, 8'd0,   8'd0, 1'b0);
    run_op(8'd6,   8'd0, 8'd3,   8'd0, 1'b0);
    run_op(8'h80,  8'd0, 8'hFF,  8'd0, 1'b0);
    // restart attempt while busy must be ignored
    run_op(8'd100, 8'hD3, 8'd7,  8'hFB, 1'b1);

    // reset in the middle of an operation (outputs are nonzero beforehand)
    A1 = 8'd50; A2 = 8'd9; B1 = 8'd3; B2 = 8'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_out1", Out1, 0);
    check("abort_out2", Out2, 0);
    check("abort_dbz", DivByZero, 0);
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (30) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    check("abort_no_done", saw_done, 0);

    // randomized operands, divisor forced to zero now and then
    for (int i = 0; i < 40; i++) begin
      logic [N-1:0] ra1, ra2, rb1, rb2;
      ra1 = N'($urandom_range(0, 255));
      ra2 = N'($urandom_range(0, 255));
      rb1 = N'($urandom_range(0, 255));
      rb2 = N'($urandom_range(0, 255));
      if ($urandom_range(0, 7) == 0) begin rb1 = '0; rb2 = '0; end
      else if ($urandom_range(0, 3) == 0) rb2 = '0;
      run_op(ra1, ra2, rb1, rb2, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
